// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the two-port data-memory arbiter.
//   arb_state_t : arbiter FSM state encoding (IDLE / OWN0 / OWN1)
//   NPORTS      : number of requesting ports
//   word_t      : 32-bit data/address word
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int NPORTS = 2;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter_rr_pick2.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin selector.
// Ports:
//   i_req  [1:0] : per-port request
//   i_last       : index of the port that was served most recently
//   o_gnt  [1:0] : one-hot pick (zero when nobody requests)
// On a conflict the port that was not served last wins.
// -----------------------------------------------------------------------------
module rr_pick2 (
  input  logic       i_req_0,
  input  logic       i_req_1,
  input  logic       i_last,
  output logic [1:0] o_gnt
);

  always_comb begin
    o_gnt = 2'b00;
    case ({i_req_1, i_req_0})
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule : rr_pick2

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-ported data memory (async read, write at posedge clk)
// between port 0 (CPU load/store) and port 1 (DMA / test loader).
// At most one access is accepted per cycle; an access is accepted when
// req[i] & gnt[i].
//
// Parameters:
//   DEPTH    : memory size in 32-bit words (word index = addr[31:2])
//   MAX_LOCK : max consecutive locked accesses by one port while the other
//              port is requesting
//
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   req/we/lock [1:0]   : per-port request, write enable, keep-ownership
//   addr/wdata  [1:0]   : per-port byte address (word aligned), write data
//   gnt         [1:0]   : combinational grant
//   rvalid/rdata/err    : registered response (reads and errored accesses)
//   mem_we/mem_a/mem_wd : memory write enable, address, write data
//   mem_rd              : memory read data (combinational)
//
// Optional build macro DMEM_ARB_STATS_EN adds:
//   acc_cnt      [1:0][31:0] : accepted accesses per port (wrapping)
//   conflict_cnt [31:0]      : cycles with both ports requesting (wrapping)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; round-robin pick between requesters
// OWN0  | port 0 holds a lock; only port 0 can be granted
// OWN1  | port 1 holds a lock; only port 1 can be granted
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DEPTH    = 64,
  parameter int MAX_LOCK = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NPORTS-1:0]        req,
  input  logic [NPORTS-1:0]        we,
  input  logic [NPORTS-1:0]        lock,
  input  logic [NPORTS-1:0][31:0]  addr,
  input  logic [NPORTS-1:0][31:0]  wdata,
  output logic [NPORTS-1:0]        gnt,
  output logic [NPORTS-1:0]        rvalid,
  output logic [NPORTS-1:0][31:0]  rdata,
  output logic [NPORTS-1:0]        err,
  output logic                     mem_we,
  output word_t                    mem_a,
  output word_t                    mem_wd,
  input  word_t                    mem_rd
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [NPORTS-1:0][31:0]  acc_cnt,
  output logic [31:0]              conflict_cnt
`endif
);

  localparam int LCW = $clog2(MAX_LOCK + 1);

  arb_state_t              r_state;
  logic                    r_last;
  logic [LCW-1:0]          r_lock_cnt;
  logic [NPORTS-1:0]       r_rvalid;
  logic [NPORTS-1:0][31:0] r_rdata;
  logic [NPORTS-1:0]       r_err;

  logic [NPORTS-1:0] w_pick;
  logic [NPORTS-1:0] w_gnt;
  logic [NPORTS-1:0] w_acc;
  logic              w_any;
  logic              w_sel;
  logic              w_lock_full;
  logic              w_break;
  logic              w_in_range;
  word_t             w_addr_sel;

  rr_pick2 u_pick (
    .i_req_0 (req[0]),
    .i_req_1 (req[1]),
    .i_last  (r_last),
    .o_gnt   (w_pick)
  );

  assign w_lock_full = (r_lock_cnt == LCW'(MAX_LOCK));

  // Grant generation. In an OWN state the owner is served unless its lock
  // budget is spent and the other port is waiting; then nobody is granted
  // for one cycle and the FSM falls back to IDLE.
  always_comb begin
    w_gnt   = 2'b00;
    w_break = 1'b0;
    if (!reset) begin
      case (r_state)
        IDLE: w_gnt = w_pick;
        OWN0: begin
          if (w_lock_full && req[1]) w_break = 1'b1;
          else if (req[0])           w_gnt   = 2'b01;
        end
        OWN1: begin
          if (w_lock_full && req[0]) w_break = 1'b1;
          else if (req[1])           w_gnt   = 2'b10;
        end
        default: w_gnt = 2'b00;
      endcase
    end
  end

  assign gnt        = w_gnt;
  assign w_acc      = req & w_gnt;
  assign w_any      = |w_acc;
  assign w_sel      = w_acc[1];
  assign w_addr_sel = addr[w_sel];
  assign w_in_range = ({2'b00, w_addr_sel[31:2]} < 32'(DEPTH));

  assign mem_a  = w_any ? w_addr_sel    : '0;
  assign mem_wd = w_any ? wdata[w_sel]  : '0;
  assign mem_we = w_any & we[w_sel] & w_in_range;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_lock_cnt <= '0;
      r_rvalid   <= '0;
      r_rdata    <= '0;
      r_err      <= '0;
    end else begin
      r_rvalid <= '0;

      if (w_any) begin
        r_last <= w_sel;
        // In-range writes complete silently; everything else answers.
        if (!we[w_sel] || !w_in_range) begin
          r_rvalid[w_sel] <= 1'b1;
          r_rdata[w_sel]  <= w_in_range ? mem_rd : 32'h0;
          r_err[w_sel]    <= ~w_in_range;
        end
      end

      case (r_state)
        IDLE: begin
          if (w_any && lock[w_sel]) begin
            r_state    <= w_sel ? OWN1 : OWN0;
            r_lock_cnt <= LCW'(1);
          end
        end
        OWN0, OWN1: begin
          if (w_break) begin
            r_state <= IDLE;
            r_last  <= (r_state == OWN1);
          end else if (w_any && lock[w_sel]) begin
            if (!w_lock_full) r_lock_cnt <= r_lock_cnt + LCW'(1);
          end else begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rvalid = r_rvalid;
  assign rdata  = r_rdata;
  assign err    = r_err;

`ifdef DMEM_ARB_STATS_EN
  logic [NPORTS-1:0][31:0] r_acc_cnt;
  logic [31:0]             r_conflict_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_acc_cnt      <= '0;
      r_conflict_cnt <= '0;
    end else begin
      if (w_acc[0])      r_acc_cnt[0]   <= r_acc_cnt[0] + 32'd1;
      if (w_acc[1])      r_acc_cnt[1]   <= r_acc_cnt[1] + 32'd1;
      if (req == 2'b11)  r_conflict_cnt <= r_conflict_cnt + 32'd1;
    end
  end

  assign acc_cnt      = r_acc_cnt;
  assign conflict_cnt = r_conflict_cnt;
`endif

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  logic             clk;
  logic             reset;
  logic [1:0]       req, we, lock;
  logic [1:0][31:0] addr, wdata;
  logic [1:0]       gnt, rvalid, err;
  logic [1:0][31:0] rdata;
  logic             mem_we;
  logic [31:0]      mem_a, mem_wd, mem_rd;
`ifdef DMEM_ARB_STATS_EN
  logic [1:0][31:0] acc_cnt;
  logic [31:0]      conflict_cnt;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] tb_mem [0:63];

  dmem_arbiter #(.DEPTH(64), .MAX_LOCK(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .we     (we),
    .lock   (lock),
    .addr   (addr),
    .wdata  (wdata),
    .gnt    (gnt),
    .rvalid (rvalid),
    .rdata  (rdata),
    .err    (err),
    .mem_we (mem_we),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_rd (mem_rd)
`ifdef DMEM_ARB_STATS_EN
    ,
    .acc_cnt      (acc_cnt),
    .conflict_cnt (conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: async read, write at posedge.
  assign mem_rd = tb_mem[mem_a[7:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_a[7:2]] <= mem_wd;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs mid-cycle.
  task automatic mid();
    #4;
  endtask

  initial begin
    logic [1:0] exp_gnt;
    int         k;

    for (int i = 0; i < 64; i++) tb_mem[i] <= 32'h0;
    tb_mem[0] <= 32'h1111_1111;
    tb_mem[1] <= 32'h2222_2222;

    reset = 1'b1;
    req = 2'b11; we = 2'b11; lock = 2'b00;
    addr[0] = 32'h0; addr[1] = 32'h4;
    wdata[0] = 32'hFFFF_FFFF; wdata[1] = 32'hEEEE_EEEE;
    cyc();
    mid();
    check("reset_gnt", 64'(gnt), 64'(2'b00));
    check("reset_mem_we", 64'(mem_we), 64'(1'b0));
    cyc();
    check("reset_rvalid", 64'(rvalid), 64'(2'b00));
    check("reset_rdata", 64'(rdata), 64'(0));
    check("reset_err", 64'(err), 64'(2'b00));

    // Write then read back on port 0.
    reset = 1'b0;
    req = 2'b01; we = 2'b01; addr[0] = 32'h10; wdata[0] = 32'hDEAD_BEEF;
    mid();
    check("wr_gnt", 64'(gnt), 64'(2'b01));
    check("wr_mem_we", 64'(mem_we), 64'(1'b1));
    check("wr_mem_a", 64'(mem_a), 64'(32'h10));
    check("wr_mem_wd", 64'(mem_wd), 64'(32'hDEAD_BEEF));
    cyc();
    check("wr_no_rvalid", 64'(rvalid), 64'(2'b00));
    we = 2'b00;
    mid();
    check("rd_gnt", 64'(gnt), 64'(2'b01));
    check("rd_mem_we", 64'(mem_we), 64'(1'b0));
    cyc();
    check("rd_rvalid", 64'(rvalid), 64'(2'b01));
    check("rd_rdata", 64'(rdata[0]), 64'(32'hDEAD_BEEF));
    check("rd_err", 64'(err), 64'(2'b00));

    // Both ports reading every cycle; last=0 so port 1 goes first.
    req = 2'b11; we = 2'b00; lock = 2'b00;
    addr[0] = 32'h0; addr[1] = 32'h4;
    for (int c = 0; c < 4; c++) begin
      exp_gnt = (c % 2 == 0) ? 2'b10 : 2'b01;
      mid();
      check("alt_gnt", 64'(gnt), 64'(exp_gnt));
      cyc();
      check("alt_rvalid", 64'(rvalid), 64'(exp_gnt));
      if (exp_gnt == 2'b10) check("alt_rdata1", 64'(rdata[1]), 64'(32'h2222_2222));
      else                  check("alt_rdata0", 64'(rdata[0]), 64'(32'h1111_1111));
    end

    // Port 1 locked burst of 12 writes while port 0 reads continuously.
    k = 0;
    for (int c = 1; c <= 14; c++) begin
      req = (k < 12) ? 2'b11 : 2'b01;
      we  = 2'b10;
      lock = (k == 11) ? 2'b00 : 2'b10;
      addr[0] = 32'h0;
      addr[1] = 32'h20 + 32'(4 * k);
      wdata[1] = 32'hA000_0000 + 32'(k);
      if (c <= 8)       exp_gnt = 2'b10;
      else if (c == 9)  exp_gnt = 2'b00;
      else if (c == 10) exp_gnt = 2'b01;
      else              exp_gnt = 2'b10;
      mid();
      check("burst_gnt", 64'(gnt), 64'(exp_gnt));
      check("burst_mem_we", 64'(mem_we), 64'(exp_gnt == 2'b10));
      if (gnt[1]) k++;
      cyc();
      if (c == 10) begin
        check("burst_p0_rvalid", 64'(rvalid), 64'(2'b01));
        check("burst_p0_rdata", 64'(rdata[0]), 64'(32'h1111_1111));
      end
    end
    check("burst_count", 64'(k), 64'(12));
    for (int w = 0; w < 12; w++)
      check("burst_mem", 64'(tb_mem[8 + w]), 64'(32'hA000_0000 + 32'(w)));

    // Out-of-range write on port 0.
    req = 2'b01; we = 2'b01; lock = 2'b00;
    addr[0] = 32'h100; wdata[0] = 32'h0000_0BAD;
    mid();
    check("oor_gnt", 64'(gnt), 64'(2'b01));
    check("oor_mem_we", 64'(mem_we), 64'(1'b0));
    cyc();
    check("oor_rvalid", 64'(rvalid), 64'(2'b01));
    check("oor_err", 64'(err), 64'(2'b01));
    check("oor_rdata", 64'(rdata[0]), 64'(0));
    we = 2'b00; addr[0] = 32'h0;
    mid();
    cyc();
    check("oor_word0", 64'(rdata[0]), 64'(32'h1111_1111));
    check("oor_err_clr", 64'(err), 64'(2'b00));

    // Reset in the middle of a port 0 lock.
    req = 2'b01; we = 2'b00; lock = 2'b01; addr[0] = 32'h0;
    cyc();
    mid();
    check("own0_gnt", 64'(gnt), 64'(2'b01));
    cyc();
    reset = 1'b1; req = 2'b11; we = 2'b11; addr[1] = 32'h4;
    mid();
    check("rst_lock_gnt", 64'(gnt), 64'(2'b00));
    check("rst_lock_mem_we", 64'(mem_we), 64'(1'b0));
    cyc();
    check("rst_lock_rvalid", 64'(rvalid), 64'(2'b00));
    reset = 1'b0; we = 2'b00; lock = 2'b00;
    mid();
    check("post_rst_gnt0", 64'(gnt), 64'(2'b01));
    cyc();
    check("post_rst_rvalid", 64'(rvalid), 64'(2'b01));
    check("post_rst_rdata", 64'(rdata[0]), 64'(32'h1111_1111));
    mid();
    check("post_rst_gnt1", 64'(gnt), 64'(2'b10));
    cyc();

    // Solo lock saturates; a late requester breaks it at once.
    req = 2'b01; lock = 2'b01;
    for (int c = 0; c < 10; c++) begin
      mid();
      check("sat_gnt", 64'(gnt), 64'(2'b01));
      cyc();
    end
    req = 2'b11;
    mid();
    check("sat_break_gnt", 64'(gnt), 64'(2'b00));
    cyc();
    lock = 2'b00;
    mid();
    check("sat_after_gnt", 64'(gnt), 64'(2'b10));
    cyc();
    req = 2'b00;
    mid();
    check("idle_gnt", 64'(gnt), 64'(2'b00));
    check("idle_mem_a", 64'(mem_a), 64'(0));
    cyc();

`ifdef DMEM_ARB_STATS_EN
    reset = 1'b1; req = 2'b00;
    cyc();
    reset = 1'b0;
    check("stats_reset", 64'(conflict_cnt), 64'(0));
    req = 2'b11; we = 2'b00; lock = 2'b00;
    for (int c = 0; c < 5; c++) cyc();
    req = 2'b10;
    for (int c = 0; c < 3; c++) cyc();
    req = 2'b00;
    cyc();
    check("stats_conflict", 64'(conflict_cnt), 64'(5));
    check("stats_acc0", 64'(acc_cnt[0]), 64'(3));
    check("stats_acc1", 64'(acc_cnt[1]), 64'(5));
    check("stats_total", 64'(acc_cnt[0] + acc_cnt[1]), 64'(8));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter
